// File: rtl/ysyx_25060170_lsu_pkg.sv
// ysyx_25060170_lsu_pkg: shared LSU states, size codes, constants and the misalignment check
package ysyx_25060170_lsu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} lsu_state_e;
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [31:0] ysyx_25060170_ZERO32 = 32'h0;
  localparam logic ysyx_25060170_RSTABLE = 1'b0;
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SIZE_H && off[0]) || (size == SIZE_W && off != 2'b00);
  endfunction
endpackage

// File: rtl/ysyx_25060170_lsu_if.sv
// ysyx_25060170_lsu_if: execute, write-back and memory-port signals of the LSU
interface ysyx_25060170_lsu_if;
  logic        ex_valid;
  logic        ls_ready;
  logic [31:0] exu_res;
  logic [31:0] store_data;
  logic        mem_ren;
  logic        mem_wen;
  logic [1:0]  mem_size;
  logic        mem_unsigned;
  logic [4:0]  rd_addr_i;
  logic        ls_valid;
  logic        wb_ready;
  logic [31:0] lsu_res;
  logic [4:0]  rd_addr_o;
  logic        ls_misalign;
  logic        ls_bus_err;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_req_wen;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_rdata;
  // master: the LSU itself; slave: the surrounding pipeline and memory
  modport master (
    input  ex_valid, exu_res, store_data, mem_ren, mem_wen, mem_size, mem_unsigned, rd_addr_i,
           wb_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    output ls_ready, ls_valid, lsu_res, rd_addr_o, ls_misalign, ls_bus_err,
           mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );
  modport slave (
    output ex_valid, exu_res, store_data, mem_ren, mem_wen, mem_size, mem_unsigned, rd_addr_i,
           wb_ready, mem_req_ready, mem_rsp_valid, mem_rsp_rdata,
    input  ls_ready, ls_valid, lsu_res, rd_addr_o, ls_misalign, ls_bus_err,
           mem_req_valid, mem_req_addr, mem_req_wen, mem_req_wdata, mem_req_wmask
  );
endinterface

// File: rtl/ysyx_25060170_lsu_align.sv
// ysyx_25060170_lsu_align: byte-lane mask, replicated store data and extended load data
module ysyx_25060170_lsu_align
  import ysyx_25060170_lsu_pkg::*;
(
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  input  logic [31:0] sd_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wmask_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  logic [31:0] sh;
  assign sh = rdata_i >> {off_i, 3'b000};
  // word accesses are aligned here, so sh equals rdata_i for them
  always_comb begin
    wmask_o = size_i == SIZE_B ? 4'b0001 << off_i : size_i == SIZE_H ? 4'b0011 << off_i : 4'b1111;
    wdata_o = size_i == SIZE_B ? {4{sd_i[7:0]}} : size_i == SIZE_H ? {2{sd_i[15:0]}} : sd_i;
    ldata_o = size_i == SIZE_B ? {{24{~uns_i & sh[7]}}, sh[7:0]} :
              size_i == SIZE_H ? {{16{~uns_i & sh[15]}}, sh[15:0]} : sh;
  end
endmodule

// File: rtl/ysyx_25060170_lsu.sv
// ysyx_25060170_lsu: single-outstanding load/store unit with registered write-back result
module ysyx_25060170_lsu
  import ysyx_25060170_lsu_pkg::*;
#(
  parameter int RSP_TIMEOUT = 255,
  parameter int CNT_W       = 8
) (
  input logic                 clk,
  input logic                 rst,
  ysyx_25060170_lsu_if.master bus
);
  lsu_state_e  st_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]  off_q, size_q;
  logic        uns_q, ren_q;
  logic        ls_valid_q, mis_q, err_q, req_valid_q, req_wen_q;
  logic [31:0] lsu_res_q, req_addr_q, wdata_q;
  logic [3:0]  wmask_q;
  logic [4:0]  rd_q;
  logic        mem_op, mis;
  logic [3:0]  a_wmask;
  logic [31:0] a_wdata, a_ldata;
  assign mem_op = bus.mem_ren | bus.mem_wen;
  assign mis    = misaligned(bus.mem_size, bus.exu_res[1:0]);
  // lanes come from the live inputs while accepting, from the captured op afterwards
  ysyx_25060170_lsu_align u_align (
    .off_i  (st_q == S_IDLE ? bus.exu_res[1:0] : off_q),
    .size_i (st_q == S_IDLE ? bus.mem_size : size_q),
    .uns_i  (uns_q),
    .sd_i   (bus.store_data),
    .rdata_i(bus.mem_rsp_rdata),
    .wmask_o(a_wmask),
    .wdata_o(a_wdata),
    .ldata_o(a_ldata)
  );
  assign bus.ls_ready      = st_q == S_IDLE;
  assign bus.ls_valid      = ls_valid_q;
  assign bus.lsu_res       = lsu_res_q;
  assign bus.rd_addr_o     = rd_q;
  assign bus.ls_misalign   = mis_q;
  assign bus.ls_bus_err    = err_q;
  assign bus.mem_req_valid = req_valid_q;
  assign bus.mem_req_addr  = req_addr_q;
  assign bus.mem_req_wen   = req_wen_q;
  assign bus.mem_req_wdata = wdata_q;
  assign bus.mem_req_wmask = wmask_q;
  // FSM: accept, request handshake, response wait with timeout, result handshake
  always_ff @(posedge clk) begin
    if (rst == ysyx_25060170_RSTABLE) begin
      st_q        <= S_IDLE;
      cnt_q       <= '0;
      off_q       <= '0;
      size_q      <= '0;
      uns_q       <= 1'b0;
      ren_q       <= 1'b0;
      ls_valid_q  <= 1'b0;
      mis_q       <= 1'b0;
      err_q       <= 1'b0;
      req_valid_q <= 1'b0;
      req_wen_q   <= 1'b0;
      lsu_res_q   <= ysyx_25060170_ZERO32;
      req_addr_q  <= ysyx_25060170_ZERO32;
      wdata_q     <= ysyx_25060170_ZERO32;
      wmask_q     <= '0;
      rd_q        <= '0;
    end else begin
      case (st_q)
        S_IDLE: if (bus.ex_valid) begin
          off_q     <= bus.exu_res[1:0];
          size_q    <= bus.mem_size;
          uns_q     <= bus.mem_unsigned;
          ren_q     <= bus.mem_ren;
          rd_q      <= bus.rd_addr_i;
          cnt_q     <= '0;
          err_q     <= 1'b0;
          mis_q     <= mem_op & mis;
          lsu_res_q <= mem_op ? ysyx_25060170_ZERO32 : bus.exu_res;
          if (!mem_op || mis) begin
            st_q       <= S_DONE;
            ls_valid_q <= 1'b1;
          end else begin
            st_q        <= S_REQ;
            req_valid_q <= 1'b1;
            req_addr_q  <= {bus.exu_res[31:2], 2'b00};
            req_wen_q   <= bus.mem_wen;
            wdata_q     <= a_wdata;
            wmask_q     <= a_wmask;
          end
        end
        S_REQ: if (bus.mem_req_ready) begin
          st_q        <= S_WAIT;
          req_valid_q <= 1'b0;
        end
        S_WAIT: if (bus.mem_rsp_valid) begin
          st_q       <= S_DONE;
          ls_valid_q <= 1'b1;
          if (ren_q) lsu_res_q <= a_ldata;
        end else if (cnt_q == CNT_W'(RSP_TIMEOUT - 1)) begin
          st_q       <= S_DONE;
          ls_valid_q <= 1'b1;
          err_q      <= 1'b1;
          lsu_res_q  <= ysyx_25060170_ZERO32;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
        S_DONE: if (bus.wb_ready) begin
          st_q       <= S_IDLE;
          ls_valid_q <= 1'b0;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ysyx_25060170_lsu.sv
// tb_ysyx_25060170_lsu: directed scenario bench for the load/store unit
module tb_ysyx_25060170_lsu;
  import ysyx_25060170_lsu_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  ysyx_25060170_lsu_if bus();
  ysyx_25060170_lsu dut (.clk(clk), .rst(rst), .bus(bus));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] sd, input logic ren, input logic wen,
                       input logic [1:0] sz, input logic uns, input logic [4:0] rd);
    bus.exu_res = a;
    bus.store_data = sd;
    bus.mem_ren = ren;
    bus.mem_wen = wen;
    bus.mem_size = sz;
    bus.mem_unsigned = uns;
    bus.rd_addr_i = rd;
    bus.ex_valid = 1'b1;
    step();
    bus.ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] f;
    bus.ex_valid = 0; bus.exu_res = 0; bus.store_data = 0; bus.mem_ren = 0; bus.mem_wen = 0;
    bus.mem_size = 0; bus.mem_unsigned = 0; bus.rd_addr_i = 0; bus.wb_ready = 0;
    bus.mem_req_ready = 0; bus.mem_rsp_valid = 0; bus.mem_rsp_rdata = 0;
    rst = 1'b0;
    step();
    step();
    f = {bus.ls_valid, bus.mem_req_valid, bus.ls_misalign, bus.ls_bus_err, bus.ls_ready};
    n_chk++;
    if (f !== 5'b00001) begin n_fail++; $display("FAIL reset_flags got %b exp 00001", f); end
    n_chk++;
    if ({bus.lsu_res, bus.mem_req_addr, bus.mem_req_wdata} !== 96'h0) begin
      n_fail++; $display("FAIL reset_data got %h %h %h exp 0", bus.lsu_res, bus.mem_req_addr, bus.mem_req_wdata);
    end
    n_chk++;
    if ({bus.rd_addr_o, bus.mem_req_wmask, bus.mem_req_wen} !== 10'h0) begin
      n_fail++; $display("FAIL reset_ctl got %h %b %b exp 0", bus.rd_addr_o, bus.mem_req_wmask, bus.mem_req_wen);
    end
    rst = 1'b1;
  endtask

  task automatic test_nonmem();
    bus.wb_ready = 1;
    issue(32'h1234_5678, 32'h0, 0, 0, SIZE_W, 0, 5'd7);
    n_chk++;
    if ({bus.ls_valid, bus.mem_req_valid, bus.ls_misalign, bus.ls_ready} !== 4'b1000) begin
      n_fail++; $display("FAIL nonmem_flags got %b exp 1000", {bus.ls_valid, bus.mem_req_valid, bus.ls_misalign, bus.ls_ready});
    end
    n_chk++;
    if (bus.lsu_res !== 32'h1234_5678) begin n_fail++; $display("FAIL nonmem_res got %h exp 12345678", bus.lsu_res); end
    n_chk++;
    if (bus.rd_addr_o !== 5'd7) begin n_fail++; $display("FAIL nonmem_rd got %0d exp 7", bus.rd_addr_o); end
    step();
    n_chk++;
    if ({bus.ls_valid, bus.mem_req_valid, bus.ls_ready} !== 3'b001) begin
      n_fail++; $display("FAIL nonmem_after got %b exp 001", {bus.ls_valid, bus.mem_req_valid, bus.ls_ready});
    end
  endtask

  task automatic test_sb();
    bus.wb_ready = 1; bus.mem_req_ready = 1; bus.mem_rsp_valid = 0;
    issue(32'h8000_0003, 32'h0000_00AB, 0, 1, SIZE_B, 0, 5'd3);
    n_chk++;
    if ({bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_addr} !== {2'b11, 32'h8000_0000}) begin
      n_fail++; $display("FAIL sb_req got v%b w%b %h exp v1 w1 80000000", bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_addr);
    end
    n_chk++;
    if ({bus.mem_req_wmask, bus.mem_req_wdata} !== {4'b1000, 32'hABAB_ABAB}) begin
      n_fail++; $display("FAIL sb_lanes got %b %h exp 1000 abababab", bus.mem_req_wmask, bus.mem_req_wdata);
    end
    step();
    n_chk++;
    if ({bus.mem_req_valid, bus.ls_valid} !== 2'b00) begin
      n_fail++; $display("FAIL sb_wait got %b exp 00", {bus.mem_req_valid, bus.ls_valid});
    end
    bus.mem_rsp_valid = 1;
    step();
    bus.mem_rsp_valid = 0;
    n_chk++;
    if ({bus.ls_valid, bus.ls_misalign, bus.ls_bus_err, bus.rd_addr_o} !== {3'b100, 5'd3}) begin
      n_fail++; $display("FAIL sb_done got %b rd %0d exp 100 rd 3", {bus.ls_valid, bus.ls_misalign, bus.ls_bus_err}, bus.rd_addr_o);
    end
    step();
  endtask

  task automatic test_loads();
    logic [31:0] ta [6] = '{32'h8000_0002, 32'h8000_0002, 32'h8000_0003, 32'h8000_0001, 32'h8000_0004, 32'h8000_0000};
    logic [1:0]  ts [6] = '{SIZE_H, SIZE_H, SIZE_B, SIZE_B, SIZE_W, SIZE_H};
    logic        tu [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] td [6] = '{32'h8001_0000, 32'h8001_0000, 32'h8001_0000, 32'h1234_5678, 32'hDEAD_BEEF, 32'h1234_F00D};
    logic [31:0] te [6] = '{32'hFFFF_8001, 32'h0000_8001, 32'hFFFF_FF80, 32'h0000_0056, 32'hDEAD_BEEF, 32'hFFFF_F00D};
    bus.wb_ready = 1; bus.mem_req_ready = 1;
    for (int i = 0; i < 6; i++) begin
      bus.mem_rsp_valid = 1;
      bus.mem_rsp_rdata = td[i];
      issue(ta[i], 32'h0, 1, 0, ts[i], tu[i], 5'(i + 10));
      n_chk++;
      if ({bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_addr} !== {2'b10, ta[i][31:2], 2'b00}) begin
        n_fail++; $display("FAIL load%0d_req got v%b w%b %h", i, bus.mem_req_valid, bus.mem_req_wen, bus.mem_req_addr);
      end
      step();
      n_chk++;
      if (bus.ls_valid !== 1'b0) begin n_fail++; $display("FAIL load%0d_early got ls_valid %b exp 0", i, bus.ls_valid); end
      step();
      n_chk++;
      if ({bus.ls_valid, bus.ls_misalign, bus.ls_bus_err, bus.lsu_res} !== {3'b100, te[i]}) begin
        n_fail++; $display("FAIL load%0d_res got %b %h exp 100 %h", i, {bus.ls_valid, bus.ls_misalign, bus.ls_bus_err}, bus.lsu_res, te[i]);
      end
      n_chk++;
      if (bus.rd_addr_o !== 5'(i + 10)) begin n_fail++; $display("FAIL load%0d_rd got %0d exp %0d", i, bus.rd_addr_o, i + 10); end
      step();
    end
    bus.mem_rsp_valid = 0;
  endtask

  task automatic test_misalign();
    logic [31:0] ta [4] = '{32'h8000_0001, 32'h8000_0003, 32'h8000_0005, 32'h8000_0002};
    logic [1:0]  ts [4] = '{SIZE_W, SIZE_H, SIZE_H, SIZE_W};
    logic        tw [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
    bus.wb_ready = 1; bus.mem_req_ready = 1;
    for (int i = 0; i < 4; i++) begin
      issue(ta[i], 32'hFFFF_FFFF, ~tw[i], tw[i], ts[i], 0, 5'd1);
      n_chk++;
      if ({bus.ls_valid, bus.ls_misalign, bus.ls_bus_err, bus.mem_req_valid, bus.lsu_res} !== {4'b1100, 32'h0}) begin
        n_fail++; $display("FAIL mis%0d got %b %h exp 1100 0", i, {bus.ls_valid, bus.ls_misalign, bus.ls_bus_err, bus.mem_req_valid}, bus.lsu_res);
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    logic [70:0] exp_req;
    bus.wb_ready = 0; bus.mem_req_ready = 0; bus.mem_rsp_valid = 0;
    issue(32'h8000_0102, 32'h1234_BEEF, 0, 1, SIZE_H, 0, 5'd9);
    exp_req = {1'b1, 32'h8000_0100, 4'b1100, 32'hBEEF_BEEF, 1'b1, 1'b0};
    for (int i = 0; i < 5; i++) begin
      n_chk++;
      if ({bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wmask, bus.mem_req_wdata, bus.mem_req_wen, bus.ls_ready} !== exp_req) begin
        n_fail++; $display("FAIL bp_req%0d got v%b %h %b %h r%b", i, bus.mem_req_valid, bus.mem_req_addr, bus.mem_req_wmask, bus.mem_req_wdata, bus.ls_ready);
      end
      step();
    end
    bus.mem_req_ready = 1;
    step();
    bus.mem_req_ready = 0;
    bus.mem_rsp_valid = 1;
    step();
    bus.mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({bus.ls_valid, bus.ls_ready, bus.ls_bus_err, bus.ls_misalign, bus.rd_addr_o} !== {4'b1000, 5'd9}) begin
        n_fail++; $display("FAIL bp_done%0d got %b rd %0d exp 1000 rd 9", i, {bus.ls_valid, bus.ls_ready, bus.ls_bus_err, bus.ls_misalign}, bus.rd_addr_o);
      end
      step();
    end
    bus.wb_ready = 1;
    step();
    n_chk++;
    if ({bus.ls_valid, bus.ls_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release got %b exp 01", {bus.ls_valid, bus.ls_ready}); end
  endtask

  task automatic test_timeout();
    bus.wb_ready = 0; bus.mem_req_ready = 1; bus.mem_rsp_valid = 0;
    issue(32'h8000_0010, 32'h0, 1, 0, SIZE_W, 0, 5'd4);
    step();
    for (int i = 0; i < 254; i++) step();
    n_chk++;
    if (bus.ls_valid !== 1'b0) begin n_fail++; $display("FAIL timeout_early got ls_valid %b exp 0", bus.ls_valid); end
    step();
    n_chk++;
    if ({bus.ls_valid, bus.ls_bus_err, bus.ls_misalign, bus.lsu_res} !== {3'b110, 32'h0}) begin
      n_fail++; $display("FAIL timeout_err got %b %h exp 110 0", {bus.ls_valid, bus.ls_bus_err, bus.ls_misalign}, bus.lsu_res);
    end
    bus.wb_ready = 1;
    step();
  endtask

  task automatic test_reset_mid();
    bus.wb_ready = 1; bus.mem_req_ready = 0; bus.mem_rsp_valid = 0;
    issue(32'h8000_0020, 32'h0, 1, 0, SIZE_W, 0, 5'd2);
    rst = 1'b0;
    step();
    rst = 1'b1;
    n_chk++;
    if ({bus.mem_req_valid, bus.ls_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_req got %b exp 01", {bus.mem_req_valid, bus.ls_ready}); end
    bus.mem_req_ready = 1;
    issue(32'h8000_0030, 32'h0, 1, 0, SIZE_W, 0, 5'd6);
    step();
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    bus.mem_rsp_valid = 1; bus.mem_rsp_rdata = 32'hFFFF_FFFF;
    step();
    step();
    bus.mem_rsp_valid = 0;
    n_chk++;
    if ({bus.ls_valid, bus.ls_bus_err, bus.mem_req_valid, bus.ls_ready, bus.lsu_res, bus.rd_addr_o} !== {4'b0001, 37'h0}) begin
      n_fail++; $display("FAIL rst_wait got %b %h rd %0d exp 0001 0 rd 0", {bus.ls_valid, bus.ls_bus_err, bus.mem_req_valid, bus.ls_ready}, bus.lsu_res, bus.rd_addr_o);
    end
    bus.mem_rsp_rdata = 32'h0000_AB00;
    issue(32'h8000_0041, 32'h0, 1, 0, SIZE_B, 1, 5'd8);
    step();
    bus.mem_rsp_valid = 1;
    step();
    bus.mem_rsp_valid = 0;
    n_chk++;
    if ({bus.ls_valid, bus.ls_bus_err, bus.lsu_res} !== {2'b10, 32'h0000_00AB}) begin
      n_fail++; $display("FAIL rst_next got %b %h exp 10 000000ab", {bus.ls_valid, bus.ls_bus_err}, bus.lsu_res);
    end
    step();
  endtask

  task automatic test_back_to_back();
    bus.wb_ready = 1;
    bus.mem_ren = 0; bus.mem_wen = 0; bus.rd_addr_i = 5'd1;
    bus.exu_res = 32'hAAAA_0001;
    bus.ex_valid = 1;
    step();
    bus.exu_res = 32'hBBBB_0002;
    n_chk++;
    if ({bus.ls_valid, bus.ls_ready, bus.lsu_res} !== {2'b10, 32'hAAAA_0001}) begin
      n_fail++; $display("FAIL b2b_first got %b %h exp 10 aaaa0001", {bus.ls_valid, bus.ls_ready}, bus.lsu_res);
    end
    step();
    n_chk++;
    if ({bus.ls_valid, bus.ls_ready} !== 2'b01) begin n_fail++; $display("FAIL b2b_gap got %b exp 01", {bus.ls_valid, bus.ls_ready}); end
    step();
    bus.ex_valid = 0;
    n_chk++;
    if ({bus.ls_valid, bus.lsu_res} !== {1'b1, 32'hBBBB_0002}) begin
      n_fail++; $display("FAIL b2b_second got %b %h exp 1 bbbb0002", bus.ls_valid, bus.lsu_res);
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_nonmem();
    test_sb();
    test_loads();
    test_misalign();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ysyx_25060170_lsu.md
# ysyx_25060170_lsu

Load/store unit directly downstream of the execute stage. It takes the ALU result (effective address or pass-through value) and the store data over a valid/ready handshake. Memory ops run through a single-outstanding request/response memory port with byte-lane masking and load extension; every op ends in a registered result presented to write-back. Non-memory ops pass through with one cycle of latency.

## Interface
Parameters:
- RSP_TIMEOUT, 255: cycles allowed in WAIT before the bus-error completion.
- CNT_W, 8: timeout counter width; must satisfy 2^CNT_W > RSP_TIMEOUT.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-low.
- ex_valid  in  1  execute-stage output valid.
- ls_ready  out  1  LSU can accept; high only in IDLE.
- exu_res  in  32  ALU result; the effective address for memory ops.
- store_data  in  32  rs2 value for stores.
- mem_ren  in  1  load op.
- mem_wen  in  1  store op; mem_ren and mem_wen both high is illegal.
- mem_size  in  2  00 byte, 01 half, 10 word; 11 is illegal.
- mem_unsigned  in  1  zero-extend load (LBU/LHU).
- rd_addr_i  in  5  destination register, carried through.
- ls_valid  out  1  result valid to write-back.
- wb_ready  in  1  write-back accepts.
- lsu_res  out  32  load data, or exu_res for non-memory ops.
- rd_addr_o  out  5  captured rd_addr_i.
- ls_misalign  out  1  qualifies ls_valid: misaligned access.
- ls_bus_err  out  1  qualifies ls_valid: response timeout.
- mem_req_valid  out  1  bus request.
- mem_req_ready  in  1  bus accepts request.
- mem_req_addr  out  32  {addr[31:2],2'b00}.
- mem_req_wen  out  1  write request.
- mem_req_wdata  out  32  lane-replicated store data.
- mem_req_wmask  out  4  byte-lane enables.
- mem_rsp_valid  in  1  response valid; always accepted in WAIT.
- mem_rsp_rdata  in  32  read data (writes return an ignored ack).

## Operation
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE: when ex_valid is high, capture exu_res, store_data, the control fields and rd_addr_i into registers.
  - Non-memory op, or misaligned op (half with addr[0]=1, word with addr[1:0]≠0): go to DONE. lsu_res = exu_res, or 0 with ls_misalign=1 when misaligned. No bus traffic.
  - Aligned memory op: go to REQ.
- REQ: mem_req_valid=1. Address, wen, wdata and wmask are held stable until mem_req_ready; the handshake moves to WAIT.
- WAIT: the timeout counter increments each cycle.
  - mem_rsp_valid: go to DONE. A load registers the extended data.
  - Counter reaches RSP_TIMEOUT: go to DONE with ls_bus_err=1 and lsu_res=0.
- DONE: ls_valid=1 with lsu_res, rd_addr_o and the error flags stable until wb_ready. The handshake returns to IDLE.
- Write lanes:
  - wmask: byte 0001<<a[1:0]; half 0011<<a[1:0]; word 1111.
  - wdata: byte {4{sd[7:0]}}; half {2{sd[15:0]}}; word sd.
- Load extraction: shift rdata right by a[1:0]*8, take the low 8 or 16 bits, then sign- or zero-extend per mem_unsigned. A word load is passed through.
- An mem_rsp_valid outside WAIT is discarded.

## Timing
- Reset (rst=0 at an edge):
  - State goes to IDLE and the counter clears.
  - ls_valid, mem_req_valid, ls_misalign and ls_bus_err go to 0; lsu_res, mem_req_* data and rd_addr_o go to 0.
- Reset mid-transaction drops the request immediately. A late response is discarded under the IDLE rule.
- Latency, from the accept edge to ls_valid:
  - Non-memory or misaligned op: 1 cycle.
  - Memory op: 1 + request-wait cycles + 1 + response-wait cycles.
  - Zero-wait bus (ready and rsp each in the cycle after assertion): 3 cycles.
- ls_ready is combinational from state only, with no path from wb_ready. A new op is accepted in the cycle after the DONE handshake, so sustained throughput is one op per 2 cycles.
- Only one request is outstanding at a time. mem_req_valid never drops before mem_req_ready once asserted, except on reset.

## Structure
- define.v gains:
  - LSU state encodings.
  - mem_size codes (SIZE_B/H/W).
- Existing ysyx_25060170_ZERO32 and ysyx_25060170_RSTABLE (redefined 1'b0) are reused.
- Sub-module ysyx_25060170_lsu_align (combinational) produces wmask, wdata and the extended load data from the address offset, size and unsigned flag. The top holds the FSM, counter and registers.

## Test plan
- Non-memory op: exu_res=0x1234_5678, ex_valid=1 -> ls_valid one cycle later, lsu_res=0x1234_5678, mem_req_valid never asserted.
- SB: addr=0x8000_0003, sd=0x0000_00AB -> req addr 0x8000_0000, wmask 1000, wdata 0xABABABAB; after the ack, ls_valid=1.
- LH/LHU: addr 0x…2, rdata=0x8001_0000 -> LH gives 0xFFFF_8001; LHU gives 0x0000_8001.
- LW addr 0x…1 -> ls_misalign=1, lsu_res=0 after 1 cycle, no request. Also LH at offset 3 -> misaligned.
- Backpressure: mem_req_ready low for 5 cycles and wb_ready low for 3 cycles in DONE -> request fields and outputs stay stable, ls_ready=0 throughout.
- Timeout and reset: no response -> after RSP_TIMEOUT WAIT cycles, ls_bus_err=1. Reset asserted in WAIT, then a response arrives -> ignored, all outputs 0, and the next op completes normally.
